// File: rtl/mem_bank_arbiter_if.sv
// Requester-side handshake plus single-port memory bank strobes for mem_bank_arbiter.
// The arbiter attaches through the slave modport; requesters and the bank use master.
interface mem_bank_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 9
);
    logic                      hold;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      mem_wr_en;
    logic                      mem_rd_en;
    logic                      mem_chip_en;
    logic [ADDR_W-1:0]         mem_wr_addr;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic [DATA_W-1:0]         mem_wr_data;
    logic [DATA_W-1:0]         mem_rd_data;

    modport slave (
        input  hold, req, we, addr, wdata, mem_rd_data,
        output gnt, rvalid, rdata, busy,
        output mem_wr_en, mem_rd_en, mem_chip_en, mem_wr_addr, mem_rd_addr, mem_wr_data
    );

    modport master (
        output hold, req, we, addr, wdata, mem_rd_data,
        input  gnt, rvalid, rdata, busy,
        input  mem_wr_en, mem_rd_en, mem_chip_en, mem_wr_addr, mem_rd_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing one single-port memory bank among NUM_REQ requesters.
// Grants are combinational; the winning command is registered onto the bank port.
module mem_bank_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    mem_bank_arbiter_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("mem_bank_arbiter: NUM_REQ must be in 2..8");
    end
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
        $error("mem_bank_arbiter: ADDR_W too narrow for DEPTH");
    end

    logic [IdxW-1:0]    ptr_q;
    logic [IdxW-1:0]    win_idx;
    logic [IdxW-1:0]    cand_idx;
    logic [IdxW-1:0]    ptr_nxt;
    logic               win_found;
    int unsigned        cand;
    logic [NUM_REQ-1:0] gnt;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               wr_en_q;
    logic               rd_en_q;
    logic               chip_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [IdxW-1:0]    rid_q;
    logic               rsp_valid_q;
    logic [IdxW-1:0]    rsp_id_q;

    // Search ptr, ptr+1, ... wrapping at NUM_REQ; first requester with req set wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        if (!rst && !bus.hold) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand     = (32'(ptr_q) + k) % NUM_REQ;
                cand_idx = IdxW'(cand);
                if (!win_found && bus.req[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
    end

    always_comb begin
        gnt      = win_found ? (NUM_REQ'(1) << win_idx) : '0;
        ptr_nxt  = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + IdxW'(1);
        sel_we   = bus.we[win_idx];
        sel_addr = bus.addr[win_idx*ADDR_W +: ADDR_W];
        sel_data = bus.wdata[win_idx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            chip_en_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
            rid_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            wr_en_q   <= win_found & sel_we;
            rd_en_q   <= win_found & ~sel_we;
            chip_en_q <= win_found;
            if (win_found) begin
                ptr_q <= ptr_nxt;
                if (sel_we) begin
                    wr_addr_q <= sel_addr;
                    wr_data_q <= sel_data;
                end else begin
                    rd_addr_q <= sel_addr;
                    rid_q     <= win_idx;
                end
            end
            // Bank data arrives one cycle after the read strobe; tag it with the reader.
            rsp_valid_q <= rd_en_q;
            rsp_id_q    <= rid_q;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.rvalid      = rsp_valid_q ? (NUM_REQ'(1) << rsp_id_q) : '0;
    assign bus.rdata       = bus.mem_rd_data;
    assign bus.busy        = wr_en_q | rd_en_q | rsp_valid_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_chip_en = chip_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.mem_wr_data = wr_data_q;
endmodule
